// File: rtl/mask_deserializer.sv
// Receive side of the serial mask link: gathers LANE_WIDTH-bit beats and rebuilds
// the full mask word, lane i of beat k landing at bit i*S + k.
module mask_deserializer #(
    parameter int LANE_WIDTH = 20,
    parameter int WORD_WIDTH = 1080,
    parameter int STEP_SEL0  = 16,
    parameter int STEP_SEL1  = 32,
    parameter int STEP_SEL2  = 54
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            image_resolution,
    input  logic [LANE_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic                  abort,
    output logic [WORD_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  busy
);

    localparam int POS_W = $clog2(WORD_WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    logic [1:0]            r_state;
    logic [7:0]            r_beat_cnt;
    logic [7:0]            r_step;
    logic [WORD_WIDTH-1:0] r_dout;

    logic [7:0]            w_res_step;
    logic                  w_res_legal;
    logic [7:0]            w_step;
    logic [7:0]            w_beat;
    logic                  w_accept;
    logic                  w_last;
    logic [POS_W-1:0]      w_pos;
    logic [WORD_WIDTH-1:0] w_wr_mask;
    logic [WORD_WIDTH-1:0] w_wr_data;

    // NOTE: every signal driven from always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_res_legal = 1'b1;
        w_res_step  = 8'(STEP_SEL0);
        case (image_resolution)
            2'b00:   w_res_step = 8'(STEP_SEL0);
            2'b01:   w_res_step = 8'(STEP_SEL1);
            2'b10:   w_res_step = 8'(STEP_SEL2);
            default: w_res_legal = 1'b0;
        endcase
    end

    // Resolution only matters for the first beat; after that the latched step rules.
    assign w_step = (r_state == ST_IDLE) ? w_res_step : r_step;
    assign w_beat = (r_state == ST_IDLE) ? 8'd0 : r_beat_cnt;

    assign din_ready  = rst_n && (((r_state == ST_IDLE) && w_res_legal) || (r_state == ST_FILL));
    assign dout_valid = (r_state == ST_FULL);
    assign busy       = (r_state == ST_FILL);
    assign dout       = r_dout;

    assign w_accept = din_valid && din_ready;
    assign w_last   = (w_beat == (w_step - 8'd1));

    always_comb begin
        w_wr_mask = '0;
        w_wr_data = '0;
        w_pos     = '0;
        for (int i = 0; i < LANE_WIDTH; i++) begin
            if ((i * int'(w_step) + int'(w_beat)) < WORD_WIDTH) begin
                w_pos            = POS_W'(i * int'(w_step) + int'(w_beat));
                w_wr_mask[w_pos] = 1'b1;
                w_wr_data[w_pos] = din[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= 8'd0;
            r_step     <= 8'(STEP_SEL0);
            r_dout     <= '0;
        end else if (abort) begin
            // A completed frame keeps its data; only a partial one is wiped.
            if (r_state != ST_FULL) begin
                r_dout <= '0;
            end
            r_state    <= ST_IDLE;
            r_beat_cnt <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_step <= w_res_step;
                        r_dout <= w_wr_data;
                        if (w_last) begin
                            r_state    <= ST_FULL;
                            r_beat_cnt <= 8'd0;
                        end else begin
                            r_state    <= ST_FILL;
                            r_beat_cnt <= 8'd1;
                        end
                    end
                end
                ST_FILL: begin
                    if (w_accept) begin
                        r_dout <= (r_dout & ~w_wr_mask) | w_wr_data;
                        if (w_last) begin
                            r_state    <= ST_FULL;
                            r_beat_cnt <= 8'd0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 8'd1;
                        end
                    end
                end
                ST_FULL: begin
                    if (dout_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_beat_cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mask_deserializer.sv
// Self-checking bench for mask_deserializer: directed scenarios plus random traffic,
// compared cycle by cycle against a frame-level reference model.
module tb_mask_deserializer;

    localparam int LW = 20;
    localparam int WW = 1080;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    image_resolution;
    logic [LW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic          abort;
    logic [WW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          busy;

    mask_deserializer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .image_resolution (image_resolution),
        .din              (din),
        .din_valid        (din_valid),
        .din_ready        (din_ready),
        .abort            (abort),
        .dout             (dout),
        .dout_valid       (dout_valid),
        .dout_ready       (dout_ready),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: frame-level view (beats taken so far, step, expected word).
    bit            m_full = 1'b0;
    int            m_cnt  = 0;
    int            m_step = 16;
    logic [WW-1:0] m_word = '0;
    bit            obs_acc;

    function automatic int step_of(input logic [1:0] res);
        case (res)
            2'b00:   return 16;
            2'b01:   return 32;
            default: return 54;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        int first;
        first = -1;
        for (int j = WW - 1; j >= 0; j--) begin
            if (obs[j] !== exp[j]) first = j;
        end
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: first differing bit %0d observed %b expected %b", tag, first,
                   obs[first], exp[first]);
        end
    endtask

    // One clock: check outputs at the falling edge, then advance the model at the rising edge.
    task automatic tick();
        logic exp_ready;
        logic acc;
        @(negedge clk);
        exp_ready = rst_n && !m_full && (m_cnt > 0 || image_resolution != 2'b11);
        check("din_ready", 32'(din_ready), 32'(exp_ready));
        check("dout_valid", 32'(dout_valid), 32'(m_full));
        check("busy", 32'(busy), 32'(!m_full && m_cnt > 0));
        check_word("dout", dout, m_word);
        obs_acc = din_valid && din_ready;
        acc     = din_valid && exp_ready;
        @(posedge clk);
        if (!rst_n) begin
            m_full = 1'b0;
            m_cnt  = 0;
            m_word = '0;
        end else if (abort) begin
            if (!m_full) m_word = '0;
            m_full = 1'b0;
            m_cnt  = 0;
        end else if (m_full) begin
            if (dout_ready) m_full = 1'b0;
        end else if (acc) begin
            if (m_cnt == 0) begin
                m_step = step_of(image_resolution);
                m_word = '0;
            end
            for (int i = 0; i < LW; i++) m_word[i * m_step + m_cnt] = din[i];
            m_cnt++;
            if (m_cnt == m_step) begin
                m_full = 1'b1;
                m_cnt  = 0;
            end
        end
        #1;
    endtask

    task automatic beat(input logic [LW-1:0] d);
        din       = d;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    initial begin
        logic [WW-1:0] src;
        logic [WW-1:0] exp_w;
        logic [WW-1:0] saved;
        logic [WW-1:0] mask0;
        logic [LW-1:0] d;
        int            k;
        int            n;
        int            t;
        int            acc_cnt;

        rst_n            = 1'b0;
        image_resolution = 2'b00;
        din              = '0;
        din_valid        = 1'b0;
        abort            = 1'b0;
        dout_ready       = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset values, then reset applied mid-FILL at 640.
        repeat (2) tick();
        rst_n            = 1'b1;
        image_resolution = 2'b01;
        for (int b = 0; b < 10; b++) beat(LW'($urandom));
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("rst_dout_zero", 32'(dout == '0), 32'(1));
        check("rst_ready_after", 32'(obs_acc || din_ready), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));

        // 320 loopback with an 0xA5 pattern laid out by the serializer mapping.
        src = '0;
        for (int b = 0; b < 40; b++) src[b * 8 +: 8] = 8'hA5;
        image_resolution = 2'b00;
        for (int kk = 0; kk < 16; kk++) begin
            for (int i = 0; i < LW; i++) d[i] = src[i * 16 + kk];
            beat(d);
        end
        n = 16;
        while (!dout_valid && n < 40) begin
            tick();
            n++;
        end
        check("lat320_cycle", 32'(n + 1), 32'(17));
        exp_w = src;
        check_word("loop320_word", dout, exp_w);
        check("loop320_ready_full", 32'(din_ready), 32'(0));
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;

        // 1080 with din_valid dropped every third cycle.
        image_resolution = 2'b10;
        k = 0;
        t = 0;
        while (k < 54 && t < 200) begin
            din       = {LW{k[0]}};
            din_valid = (t % 3) != 2;
            tick();
            if (obs_acc) k++;
            t++;
        end
        din_valid = 1'b0;
        check("gap1080_beats", 32'(k), 32'(54));
        check("gap1080_valid_next", 32'(dout_valid), 32'(1));
        exp_w = '0;
        for (int i = 0; i < LW; i++)
            for (int kk = 0; kk < 54; kk++) exp_w[i * 54 + kk] = kk[0];
        check_word("gap1080_word", dout, exp_w);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;

        // Resolution switched after beat 5 must not change the frame length.
        image_resolution = 2'b01;
        acc_cnt = 0;
        t = 0;
        while (!dout_valid && t < 100) begin
            if (acc_cnt == 6) image_resolution = 2'b00;
            din       = LW'($urandom);
            din_valid = 1'b1;
            tick();
            if (obs_acc) acc_cnt++;
            t++;
        end
        din_valid = 1'b0;
        check("reschg_beats", 32'(acc_cnt), 32'(32));

        // Backpressure in FULL, then turnaround into a new frame.
        saved     = dout;
        din_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            din = LW'($urandom);
            tick();
            check_word("bp_dout_stable", dout, saved);
            check("bp_no_accept", 32'(obs_acc), 32'(0));
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        tick();
        dout_ready       = 1'b0;
        image_resolution = 2'b01;
        beat(LW'($urandom));
        check("turn_beat0_taken", 32'(obs_acc), 32'(1));
        mask0 = '0;
        for (int i = 0; i < LW; i++) mask0[i * 32] = 1'b1;
        check("turn_upper_zero", 32'((dout & ~mask0) == '0), 32'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Abort at beat 20 of 1080 (with a beat offered that cycle), then a 320 frame.
        image_resolution = 2'b10;
        for (int b = 0; b < 20; b++) beat(LW'($urandom));
        abort     = 1'b1;
        din       = LW'($urandom);
        din_valid = 1'b1;
        tick();
        abort     = 1'b0;
        din_valid = 1'b0;
        check("abort_idle_busy", 32'(busy), 32'(0));
        check("abort_dout_clear", 32'(dout == '0), 32'(1));
        image_resolution = 2'b00;
        for (int b = 0; b < 16; b++) beat(LW'($urandom));
        check("abort_next320_valid", 32'(dout_valid), 32'(1));
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;

        // Illegal resolution stalls the idle block.
        image_resolution = 2'b11;
        din_valid        = 1'b1;
        acc_cnt          = 0;
        for (int c = 0; c < 5; c++) begin
            din = LW'($urandom);
            tick();
            check("illegal_ready", 32'(din_ready), 32'(0));
            if (obs_acc) acc_cnt++;
        end
        din_valid = 1'b0;
        check("illegal_no_accept", 32'(acc_cnt), 32'(0));
        check("illegal_busy", 32'(busy), 32'(0));

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            image_resolution = 2'($urandom_range(3, 0));
            din              = LW'($urandom);
            din_valid        = $urandom_range(9, 0) < 7;
            dout_ready       = $urandom_range(1, 0) == 1;
            abort            = $urandom_range(60, 0) == 0;
            tick();
        end
        abort     = 1'b0;
        din_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
